// File: rtl/common_reset_gen.sv
// ---------------------------------------------------------------------------
// common_reset_gen
//
// Produces the staged reset for the subsystem. After a reset event, every
// domain is held in reset for HOLD_CYCLES cycles. The domains are then
// released one at a time, STAGE_GAP cycles apart, starting with bit 0. The
// outputs are meant to drive per-domain common_reset_sync instances.
//
// A software reset request from the register block restarts the whole
// sequence. The request is acknowledged with a one-cycle pulse. If the
// request is held high, it is accepted again on every cycle, so it keeps
// the block in the hold phase for as long as it stays high.
//
// Ports:
//   clk_i           system clock (single domain)
//   reset_i         synchronous, active-high reset; overrides everything
//   sw_reset_req_i  software reset request (level or pulse)
//   sw_reset_ack_o  one-cycle pulse when a request is accepted
//   rst_q_o         active-low stage resets, bit 0 released first
//   busy_o          high while any stage is still in reset
//   done_o          high once every stage is released
//   cause_o         (optional) 2'b01 after reset_i, 2'b10 after a sw request
//   sw_count_o      (optional) saturating count of accepted sw requests
//
// Optional feature macro: COMMON_RESET_GEN_CAUSE_EN adds cause_o and
// sw_count_o. When the macro is not defined, neither port nor its
// registers exist.
//
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module common_reset_gen #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  sw_reset_req_i,
    output logic                  sw_reset_ack_o,
    output logic [NUM_STAGES-1:0] rst_q_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef COMMON_RESET_GEN_CAUSE_EN
    ,
    output logic [1:0]            cause_o,
    output logic [7:0]            sw_count_o
`endif
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_STAGES + 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

    logic [1:0]            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_STAGES-1:0] rst_q_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ack_q;
    logic [NUM_STAGES-1:0] rst_shift;

    // Stages release strictly in order, so the next release pattern is the
    // current one shifted up with a 1 brought in at bit 0. This avoids
    // indexing rst_q_q with the stage index.
    always_comb begin
        rst_shift = (rst_q_q << 1) | NUM_STAGES'(1);
    end

    // Main sequencer. reset_i has top priority. An accepted software request
    // comes next and puts the block into exactly the same state as reset_i,
    // except that it also raises the acknowledge for one cycle. Without
    // either of those, the hold count runs, then the per-stage gap count.
    // The counter is cleared at its terminal value, so it never wraps.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else if (sw_reset_req_i) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        rst_q_q <= rst_shift;
                        // With a single stage, releasing stage 0 finishes
                        // the sequence, so the gap phase is skipped.
                        if (NUM_STAGES == 1) begin
                            state_q <= ST_RUN;
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                            idx_q   <= IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        rst_q_q <= rst_shift;
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_ASSERT;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    rst_q_q <= '0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_q_o        = rst_q_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign sw_reset_ack_o = ack_q;

`ifdef COMMON_RESET_GEN_CAUSE_EN
    logic [1:0] cause_q;
    logic [7:0] sw_count_q;

    // Records what caused the most recent reset event. It also counts the
    // accepted software requests, saturating at 255. Both update on the same
    // edge that raises the acknowledge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cause_q    <= 2'b01;
            sw_count_q <= '0;
        end else if (sw_reset_req_i) begin
            cause_q <= 2'b10;
            if (sw_count_q != 8'hFF) begin
                sw_count_q <= sw_count_q + 8'd1;
            end
        end
    end

    assign cause_o    = cause_q;
    assign sw_count_o = sw_count_q;
`endif

endmodule

// File: tb/tb_common_reset_gen.sv
// ---------------------------------------------------------------------------
// tb_common_reset_gen
//
// Drives two instances of the reset generator: one with the default
// parameters (4/16/8) and one with the minimal parameters (1/1/1).
//
// The reference model tracks a single number per instance: the age, which
// is the number of clock edges since the last reset event (reset_i or an
// accepted software request). Stage k must be released once the age reaches
// HOLD + k*GAP. The acknowledge is high in the cycle right after a request
// is accepted. Directed sequences with literal expected values follow the
// scenarios above, and a randomized phase comes after them.
// ---------------------------------------------------------------------------
module tb_common_reset_gen;

    localparam int A_NS = 4, A_HOLD = 16, A_GAP = 8;
    localparam int B_NS = 1, B_HOLD = 1,  B_GAP = 1;
    localparam int AGE_CAP = 100000;

    logic       clk = 1'b0;
    logic       reset_a = 1'b1, req_a = 1'b0;
    logic       reset_b = 1'b1, req_b = 1'b0;
    logic       ack_a, busy_a, done_a;
    logic       ack_b, busy_b, done_b;
    logic [3:0] rst_a;
    logic [0:0] rst_b;
`ifdef COMMON_RESET_GEN_CAUSE_EN
    logic [1:0] cause_a, cause_b;
    logic [7:0] cnt_a, cnt_b;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model state
    int   age_a = 0, age_b = 0;
    logic exp_ack_a = 1'b0, exp_ack_b = 1'b0;
    logic valid_a = 1'b0, valid_b = 1'b0;
    int   exp_cause_a = 0, exp_cause_b = 0;
    int   exp_cnt_a = 0, exp_cnt_b = 0;

    int burst_a = 0, burst_b = 0;

    always #5 clk = ~clk;

    common_reset_gen #(.NUM_STAGES(A_NS), .HOLD_CYCLES(A_HOLD), .STAGE_GAP(A_GAP)) dut_a (
        .clk_i          (clk),
        .reset_i        (reset_a),
        .sw_reset_req_i (req_a),
        .sw_reset_ack_o (ack_a),
        .rst_q_o        (rst_a),
        .busy_o         (busy_a),
        .done_o         (done_a)
`ifdef COMMON_RESET_GEN_CAUSE_EN
        ,
        .cause_o        (cause_a),
        .sw_count_o     (cnt_a)
`endif
    );

    common_reset_gen #(.NUM_STAGES(B_NS), .HOLD_CYCLES(B_HOLD), .STAGE_GAP(B_GAP)) dut_b (
        .clk_i          (clk),
        .reset_i        (reset_b),
        .sw_reset_req_i (req_b),
        .sw_reset_ack_o (ack_b),
        .rst_q_o        (rst_b),
        .busy_o         (busy_b),
        .done_o         (done_b)
`ifdef COMMON_RESET_GEN_CAUSE_EN
        ,
        .cause_o        (cause_b),
        .sw_count_o     (cnt_b)
`endif
    );

    // Core comparison used by every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Release pattern implied by the age: stage k is out of reset once the
    // age reaches hold + k*gap.
    function automatic logic [31:0] expStages(int age, int ns, int hold, int gap);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < ns; k++) begin
            if (age >= hold + k * gap) v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic expDone(int age, int ns, int hold, int gap);
        return age >= hold + (ns - 1) * gap;
    endfunction

    // Reference model. On each edge it classifies the event (reset, accepted
    // request, or a plain cycle) and moves the age and side counters on.
    always @(posedge clk) begin
        if (reset_a) begin
            age_a = 0; exp_ack_a = 1'b0; valid_a = 1'b1;
            exp_cause_a = 1; exp_cnt_a = 0;
        end else if (req_a) begin
            age_a = 0; exp_ack_a = 1'b1;
            exp_cause_a = 2; if (exp_cnt_a < 255) exp_cnt_a++;
        end else begin
            if (age_a < AGE_CAP) age_a++;
            exp_ack_a = 1'b0;
        end
        if (reset_b) begin
            age_b = 0; exp_ack_b = 1'b0; valid_b = 1'b1;
            exp_cause_b = 1; exp_cnt_b = 0;
        end else if (req_b) begin
            age_b = 0; exp_ack_b = 1'b1;
            exp_cause_b = 2; if (exp_cnt_b < 255) exp_cnt_b++;
        end else begin
            if (age_b < AGE_CAP) age_b++;
            exp_ack_b = 1'b0;
        end
    end

    // Compares both instances against the model on every falling edge,
    // once the first reset has made the outputs meaningful.
    always @(negedge clk) begin
        if (valid_a) begin
            checkOutput("A.rst_q", 32'(rst_a), expStages(age_a, A_NS, A_HOLD, A_GAP));
            checkOutput("A.done", 32'(done_a), 32'(expDone(age_a, A_NS, A_HOLD, A_GAP)));
            checkOutput("A.busy", 32'(busy_a), 32'(!expDone(age_a, A_NS, A_HOLD, A_GAP)));
            checkOutput("A.ack", 32'(ack_a), 32'(exp_ack_a));
`ifdef COMMON_RESET_GEN_CAUSE_EN
            checkOutput("A.cause", 32'(cause_a), 32'(exp_cause_a));
            checkOutput("A.sw_count", 32'(cnt_a), 32'(exp_cnt_a));
`endif
        end
        if (valid_b) begin
            checkOutput("B.rst_q", 32'(rst_b), expStages(age_b, B_NS, B_HOLD, B_GAP));
            checkOutput("B.done", 32'(done_b), 32'(expDone(age_b, B_NS, B_HOLD, B_GAP)));
            checkOutput("B.busy", 32'(busy_b), 32'(!expDone(age_b, B_NS, B_HOLD, B_GAP)));
            checkOutput("B.ack", 32'(ack_b), 32'(exp_ack_b));
`ifdef COMMON_RESET_GEN_CAUSE_EN
            checkOutput("B.cause", 32'(cause_b), 32'(exp_cause_b));
            checkOutput("B.sw_count", 32'(cnt_b), 32'(exp_cnt_b));
`endif
        end
    end

    // Sets instance A inputs, then advances the given number of falling edges.
    task automatic applyStimulus(input logic r, input logic q, input int cycles);
        reset_a = r;
        req_a   = q;
        repeat (cycles) @(negedge clk);
    endtask

    // Literal expectations for instance A.
    task automatic checkA(input string tag, input logic [3:0] r, input logic b,
                          input logic d, input logic a);
        checkOutput({tag, ".rst_q"}, 32'(rst_a), 32'(r));
        checkOutput({tag, ".busy"}, 32'(busy_a), 32'(b));
        checkOutput({tag, ".done"}, 32'(done_a), 32'(d));
        checkOutput({tag, ".ack"}, 32'(ack_a), 32'(a));
    endtask

    initial begin
        // Scenario 1: reset held for three cycles, then the full release sequence.
        applyStimulus(1'b1, 1'b0, 3);
        checkA("t1_reset", 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 15);
        checkA("t1_c15", 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        checkA("t1_c16", 4'b0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8);
        checkA("t1_c24", 4'b0011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8);
        checkA("t1_c32", 4'b0111, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7);
        checkA("t1_c39", 4'b0111, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        checkA("t1_c40", 4'b1111, 1'b0, 1'b1, 1'b0);

        // Scenario 2: single-cycle request while running.
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b0, 1'b1, 1);
        checkA("t2_ack", 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 15);
        checkA("t2_a15", 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        checkA("t2_a16", 4'b0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 23);
        checkA("t2_a39", 4'b0111, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        checkA("t2_a40", 4'b1111, 1'b0, 1'b1, 1'b0);

        // Scenario 3: request in the middle of the release phase.
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 28);
        checkA("t3_c28", 4'b0011, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1);
        checkA("t3_ack", 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1);
        checkA("t3_a1", 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 14);
        checkA("t3_a15", 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        checkA("t3_a16", 4'b0001, 1'b1, 1'b0, 1'b0);

        // Scenario 4: request held high for ten cycles while running.
        applyStimulus(1'b0, 1'b0, 30);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkA("t4_held", 4'b0000, 1'b1, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1);
        checkA("t4_drop1", 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 14);
        checkA("t4_d15", 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        checkA("t4_d16", 4'b0001, 1'b1, 1'b0, 1'b0);

        // Scenario 5: reset and request high together; reset wins.
        applyStimulus(1'b0, 1'b0, 30);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1);
            checkA("t5_both", 4'b0000, 1'b1, 1'b0, 1'b0);
        end
`ifdef COMMON_RESET_GEN_CAUSE_EN
        checkOutput("t5_cause", 32'(cause_a), 32'h1);
        checkOutput("t5_count", 32'(cnt_a), 32'h0);
`endif
        applyStimulus(1'b0, 1'b0, 16);
        checkA("t5_c16", 4'b0001, 1'b1, 1'b0, 1'b0);

        // Scenario 6: minimal parameters on instance B.
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
        checkOutput("t6_c0.rst", 32'(rst_b), 32'h0);
        checkOutput("t6_c0.done", 32'(done_b), 32'h0);
        @(negedge clk);
        checkOutput("t6_c1.rst", 32'(rst_b), 32'h1);
        checkOutput("t6_c1.done", 32'(done_b), 32'h1);
        checkOutput("t6_c1.busy", 32'(busy_b), 32'h0);
`ifdef COMMON_RESET_GEN_CAUSE_EN
        req_b = 1'b1;
        repeat (300) @(negedge clk);
        req_b = 1'b0;
        checkOutput("t6_sat", 32'(cnt_b), 32'd255);
        checkOutput("t6_cause", 32'(cause_b), 32'h2);
        checkOutput("t6_ack", 32'(ack_b), 32'h1);
`endif

        // Randomized phase on both instances.
        for (int c = 0; c < 2500; c++) begin
            reset_a = ($urandom_range(0, 199) == 0);
            if (burst_a > 0) begin
                req_a = 1'b1; burst_a--;
            end else if ($urandom_range(0, 63) == 0) begin
                req_a = 1'b1; burst_a = $urandom_range(0, 4);
            end else begin
                req_a = 1'b0;
            end
            reset_b = ($urandom_range(0, 49) == 0);
            if (burst_b > 0) begin
                req_b = 1'b1; burst_b--;
            end else if ($urandom_range(0, 7) == 0) begin
                req_b = 1'b1; burst_b = $urandom_range(0, 3);
            end else begin
                req_b = 1'b0;
            end
            @(negedge clk);
        end
        reset_a = 1'b0; req_a = 1'b0; reset_b = 1'b0; req_b = 1'b0;
        repeat (50) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
